rr_mux_sel_arbiter: RTL
=======================

// Module: rr_mux_sel_arbiter
// PURPOSE
//   Round-robin arbiter that drives the 2-bit select of the 8-bit 4:1 datapath mux.
//   It sits directly upstream of the mux: four sources raise REQ, the block picks one
//   fairly, holds S stable while the downstream consumer stalls, and returns a one-hot
//   GRANT on the cycle the mux output is accepted. It also counts completed transfers.
// PARAMETERS
//   CNT_W    8   width of the XFER_CNT transfer counter (wraps modulo 2^CNT_W)
// PORTS
//   CLK       in   1       rising-edge clock
//   RST_N     in   1       asynchronous reset, active-low
//   REQ       in   4       per-source request; bit i = source i (mux input A,B,C,D = 0..3)
//   READY     in   1       downstream accepts the mux output this cycle
//   S         out  2       mux select, registered
//   VALID     out  1       S is valid and the selected mux input is being offered
//   GRANT     out  4       one-hot ack to the source, asserted only on a transfer cycle
//   XFER_CNT  out  CNT_W   number of completed transfers
// BEHAVIOUR
//   Reset (RST_N low, async): S=0, VALID=0, GRANT=0, XFER_CNT=0, PTR=0, state=IDLE.
//     Deassertion is sampled on CLK; a reset mid-transfer discards the pending grant.
//   PTR (internal, 2 bits): highest-priority index. Search order PTR, PTR+1, PTR+2, PTR+3 mod 4.
//   Transfer cycle: VALID && READY. GRANT = one-hot(S) combinationally in that cycle only.
//   FSM:
//     IDLE: VALID=0. If |REQ, then on the next edge S <= first requester from PTR,
//       VALID <= 1, go to BUSY. Otherwise stay. Latency: REQ -> VALID is 1 cycle.
//     BUSY: VALID=1, S frozen while !READY (any length of stall, no timeout).
//       REQ is sticky once granted: deassertion of REQ[S] while BUSY is ignored.
//       On a transfer cycle:
//         PTR <= S+1 (mod 4, 3 wraps to 0); XFER_CNT <= XFER_CNT+1 (wraps to 0).
//         Next pick = first requester from S+1 over REQ with bit S masked.
//         If any: S <= pick, stay BUSY (back-to-back, no bubble). Else VALID <= 0, go to IDLE.
//   The served source must drop REQ in the cycle after GRANT. If it keeps REQ high,
//     that is a new request and is arbitrated normally from the following cycle.
//   REQ changes on non-served bits while BUSY affect only the next pick.
//   READY while in IDLE is ignored (no GRANT, no count).
//   All outputs except GRANT are registered. GRANT is combinational from registered S,
//     VALID and the READY input.
// TESTING
//   1 Reset: RST_N=0 mid-run with REQ=4'hF, READY=1 -> S=0, VALID=0, GRANT=0, XFER_CNT=0
//     immediately, without waiting for CLK.
//   2 Single request: REQ=4'b0100, READY=1 -> VALID=1 with S=2 after 1 cycle; next cycle
//     GRANT=4'b0100 and XFER_CNT=1. With REQ then 0 -> VALID=0.
//   3 Round-robin: REQ=4'hF held, READY=1 -> S sequence 0,1,2,3,0 with no bubble;
//     GRANT 0001,0010,0100,1000,0001; XFER_CNT increments every cycle.
//   4 Stall: REQ=4'b1010, READY=0 for 5 cycles -> S=1 constant, GRANT=0. REQ[1] dropped
//     during the stall has no effect. Then READY=1 -> GRANT=4'b0010, next S=3.
//   5 Masking/wrap: PTR=3, REQ=4'b0001 only, READY=1 -> S=0, transfer, VALID drops.
//     With REQ[0] held one extra cycle, it is re-granted from IDLE, not back-to-back.
//   6 Counter wrap: CNT_W=2, 5 transfers -> XFER_CNT sequence 1,2,3,0,1. Checked against
//     the mux model: on each GRANT, the DUT mux output F equals the input selected by S.

Source files
------------

// File: rtl/rr_mux_sel_arbiter.sv
// rtl/rr_mux_sel_arbiter.sv - round-robin select arbiter for the 8-bit 4:1 datapath mux
module rr_mux_sel_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [3:0]       REQ,
  input  logic             READY,
  output logic [1:0]       S,
  output logic             VALID,
  output logic [3:0]       GRANT,
  output logic [CNT_W-1:0] XFER_CNT
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_s;
  logic [1:0]       w_s_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic [1:0]       r_ptr;
  logic [1:0]       w_ptr_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_inc;

  logic             w_transfer;
  logic [3:0]       w_s_onehot;
  logic [3:0]       w_req_masked;
  logic [1:0]       w_s_plus1;

  // First set bit of i_req, searching upward from i_start and wrapping at 3.
  function automatic logic [1:0] rr_pick(input logic [3:0] i_req, input logic [1:0] i_start);
    logic [1:0] w_idx;
    logic [1:0] w_pick;
    logic       w_found;
    w_pick  = i_start;
    w_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_idx = i_start + 2'(k);
      if (!w_found && i_req[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
    return w_pick;
  endfunction

  assign w_transfer   = r_valid & READY;
  assign w_s_onehot   = 4'b0001 << r_s;
  // The source being served is excluded so a held REQ cannot be re-served back-to-back.
  assign w_req_masked = REQ & ~w_s_onehot;
  assign w_s_plus1    = r_s + 2'd1;

  // Next-state and next-select decision for the two-state arbiter.
  always_comb begin
    w_state_nxt = r_state;
    w_s_nxt     = r_s;
    w_valid_nxt = r_valid;
    w_ptr_nxt   = r_ptr;
    w_cnt_inc   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|REQ) begin
          w_s_nxt     = rr_pick(REQ, r_ptr);
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (READY) begin
          w_ptr_nxt = w_s_plus1;
          w_cnt_inc = 1'b1;
          if (|w_req_masked) begin
            w_s_nxt = rr_pick(w_req_masked, w_s_plus1);
          end else begin
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, select, priority pointer and transfer counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_s     <= 2'd0;
      r_valid <= 1'b0;
      r_ptr   <= 2'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_valid <= w_valid_nxt;
      r_ptr   <= w_ptr_nxt;
      if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign S        = r_s;
  assign VALID    = r_valid;
  assign GRANT    = w_transfer ? w_s_onehot : 4'b0000;
  assign XFER_CNT = r_cnt;

endmodule
